csr_reg_file: RTL and testbench
===============================

// Module: csr_reg_file
// PURPOSE
// Machine-mode CSR register file for the RV64 out-of-order core. Serves one CSR access per cycle from the
// CSR functional unit (CSRRW/CSRRS/CSRRC semantics): combinational read, write at the clock edge.
// Maintains the mcycle/minstret counters, fed by the commit stage's retire-valid pulse.
// PARAMETERS
// XLEN     64  data width of CSRs and operands
// HART_ID  0   value returned by mhartid
// PORTS
// clk          in   1     clock
// rstn         in   1     asynchronous active-low reset
// req_valid_i  in   1     CSR access this cycle
// req_op_i     in   2     01=RW 10=RS(set) 11=RC(clear); 00=no-op (read only, never writes)
// req_addr_i   in   12    CSR address
// req_wdata_i  in   XLEN  operand (rs1 value or zero-extended uimm)
// req_nowr_i   in   1     1 = RS/RC source is x0/uimm 0: suppresses write and write-illegality
// rdata_o      out  XLEN  old CSR value (combinational from req_addr_i)
// illegal_o    out  1     access illegal (valid only when req_valid_i)
// retire_i     in   1     one instruction committed this cycle
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (clk, rstn).
// - Reset values: all CSRs 0, except mstatus.MPP=2'b11 and misa constant; outputs follow (rdata_o is combinational).
// - Implemented: mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343,
//   mip 344, mcycle B00, minstret B02, mvendorid F11, marchid F12, mimpid F13, mhartid F14,
//   cycle C00, time C01 (aliases mcycle), instret C02.
// - Read: rdata_o = current value, same cycle, no dependence on req_op_i; unimplemented address -> 0.
// - Write value: RW: wdata; RS: old|wdata; RC: old&~wdata. Committed at posedge when req_valid_i & we & !illegal_o.
// - we = (op==RW) | (op in {RS,RC} & !req_nowr_i). op==00: we=0.
// - illegal_o=1 if address unimplemented, or we=1 and addr[11:10]==2'b11 (read-only space). Illegal -> no state change.
// - WARL: mstatus writable bits MIE[3], MPIE[7] only; MPP[12:11] reads 2'b11 always; others read 0.
//   misa = 64'h8000_0000_0000_0100 (MXL=2, I), writes ignored (legal, no effect).
//   mtvec bit1 hardwired 0; mepc bit0 hardwired 0; mie/mip only bits 3,7,11 writable; others full XLEN.
// - mcycle: +1 every cycle out of reset, wraps 2^64-1 -> 0; a same-cycle CSR write wins (value = written value, no +1).
// - minstret: +1 when retire_i; same-cycle CSR write wins over the increment.
// - Reset assertion mid-operation clears counters immediately (asynchronous); a pending write is lost.
// - No handshake backpressure: block accepts every valid request; no multi-cycle latency.
// STRUCTURE
// - csr_pkg: CSR address localparams, csr_op_e enum, MSTATUS/MIx write masks, MISA_VAL.
// - Sub-module csr_counter (XLEN counter with inc, wr_en, wr_data; write priority) instantiated for mcycle, minstret.
// - Remaining regs: one always_ff with async reset, plus combinational read mux and write-value/legality logic.
// TESTING
// - Reset, read 0x301 -> 8000_0000_0000_0100; read 0x300 -> 0x1800; read 0xF14 -> HART_ID; illegal_o=0.
// - RW 0x340 wdata=0xDEAD_BEEF -> rdata_o=0 that cycle; next read 0x340 -> 0xDEAD_BEEF.
// - RS 0x300 wdata=0x8 then RC wdata=0x8 -> reads 0x1808 then 0x1800; RS with req_nowr_i=1 -> no change.
// - RW 0xC00 or access to addr 0x7FF -> illegal_o=1, state unchanged; RS 0xC00 with req_nowr_i=1 -> legal read.
// - Hold 10 cycles with retire_i high 4 cycles -> mcycle advanced 10, minstret 4; RW 0xB00=5 -> next cycle 5, then 6.
// - Write mepc=0x1003, mtvec=0x1003 -> read 0x1002 and 0x1001; assert rstn mid-run -> counters 0 immediately.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, access opcodes, WARL masks.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus keeps only MIE/MPIE; MPP is hardwired to machine mode on read.
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MSTATUS_MPP   = 64'h0000_0000_0000_1800;
    localparam logic [63:0] MIX_WMASK     = 64'h0000_0000_0000_0888;
    localparam logic [63:0] MISA_VAL      = 64'h8000_0000_0000_0100;

endpackage

// File: rtl/csr_counter.sv
// Free-running CSR counter with an increment enable and a CSR write that overrides the increment.
module csr_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (wr_en) begin
            count <= wr_data;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/csr_reg_file.sv
// Machine-mode CSR register file: combinational read of the old value, CSRRW/RS/RC write at the clock edge,
// plus mcycle/minstret counters.
module csr_reg_file
    import csr_pkg::*;
#(
    parameter int          XLEN    = 64,
    parameter int unsigned HART_ID = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid_i,
    input  logic [1:0]      req_op_i,
    input  logic [11:0]     req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic            req_nowr_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    input  logic            retire_i
);

    // Requests are valid-only: every cycle with req_valid_i high is accepted and completes that cycle.
    csr_op_e         op;
    logic            we;
    logic            hit;
    logic            illegal;
    logic            commit;
    logic [XLEN-1:0] wval;
    logic [XLEN-1:0] mcycle, minstret;
    logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;

    assign op = csr_op_e'(req_op_i);

    always_comb begin
        rdata_o = '0;
        hit     = 1'b1;
        case (req_addr_i)
            CSR_MSTATUS:                         rdata_o = mstatus_q | XLEN'(MSTATUS_MPP);
            CSR_MISA:                            rdata_o = XLEN'(MISA_VAL);
            CSR_MIE:                             rdata_o = mie_q;
            CSR_MTVEC:                           rdata_o = mtvec_q;
            CSR_MSCRATCH:                        rdata_o = mscratch_q;
            CSR_MEPC:                            rdata_o = mepc_q;
            CSR_MCAUSE:                          rdata_o = mcause_q;
            CSR_MTVAL:                           rdata_o = mtval_q;
            CSR_MIP:                             rdata_o = mip_q;
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME:     rdata_o = mcycle;
            CSR_MINSTRET, CSR_INSTRET:           rdata_o = minstret;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata_o = '0;
            CSR_MHARTID:                         rdata_o = XLEN'(HART_ID);
            default:                             hit = 1'b0;
        endcase
    end

    always_comb begin
        we   = 1'b0;
        wval = rdata_o;
        case (op)
            CSR_OP_RW: begin
                we   = 1'b1;
                wval = req_wdata_i;
            end
            CSR_OP_RS: begin
                we   = !req_nowr_i;
                wval = rdata_o | req_wdata_i;
            end
            CSR_OP_RC: begin
                we   = !req_nowr_i;
                wval = rdata_o & ~req_wdata_i;
            end
            default: ;
        endcase
    end

    // Addresses 0xC00-0xFFF are read-only; a suppressed write there is still a legal read.
    assign illegal   = !hit || (we && (req_addr_i[11:10] == 2'b11));
    assign illegal_o = req_valid_i && illegal;
    assign commit    = req_valid_i && we && !illegal;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
        end else if (commit) begin
            case (req_addr_i)
                CSR_MSTATUS:  mstatus_q  <= wval & XLEN'(MSTATUS_WMASK);
                CSR_MIE:      mie_q      <= wval & XLEN'(MIX_WMASK);
                CSR_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], 1'b0, wval[0]};
                CSR_MSCRATCH: mscratch_q <= wval;
                CSR_MEPC:     mepc_q     <= {wval[XLEN-1:1], 1'b0};
                CSR_MCAUSE:   mcause_q   <= wval;
                CSR_MTVAL:    mtval_q    <= wval;
                CSR_MIP:      mip_q      <= wval & XLEN'(MIX_WMASK);
                default: ;
            endcase
        end
    end

    csr_counter #(.W(XLEN)) u_mcycle (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (1'b1),
        .wr_en   (commit && (req_addr_i == CSR_MCYCLE)),
        .wr_data (wval),
        .count   (mcycle)
    );

    csr_counter #(.W(XLEN)) u_minstret (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (retire_i),
        .wr_en   (commit && (req_addr_i == CSR_MINSTRET)),
        .wr_data (wval),
        .count   (minstret)
    );

endmodule

// File: tb/tb_csr_reg_file.sv
// Bench for csr_reg_file: directed scenarios plus random accesses checked against an address-map reference model.
module tb_csr_reg_file;

    localparam int          XLEN = 64;
    localparam int unsigned HART = 3;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req_valid_i = 1'b0;
    logic [1:0]      req_op_i = 2'b00;
    logic [11:0]     req_addr_i = 12'h000;
    logic [XLEN-1:0] req_wdata_i = '0;
    logic            req_nowr_i = 1'b0;
    logic            retire_i = 1'b0;
    logic [XLEN-1:0] rdata_o;
    logic            illegal_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    csr_reg_file #(.XLEN(XLEN), .HART_ID(HART)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid_i),
        .req_op_i    (req_op_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_nowr_i  (req_nowr_i),
        .rdata_o     (rdata_o),
        .illegal_o   (illegal_o),
        .retire_i    (retire_i)
    );

    always #5 clk = ~clk;

    // Reference model: a flat CSR storage array plus two counters.
    logic [63:0] m_mem [0:4095];
    logic [63:0] m_cycle;
    logic [63:0] m_instret;

    function automatic bit m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
            12'hB00, 12'hB02, 12'hC00, 12'hC01, 12'hC02,
            12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mem[a] | 64'h1800;
            12'h301: return 64'h8000_0000_0000_0100;
            12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344: return m_mem[a];
            12'hB00, 12'hC00, 12'hC01: return m_cycle;
            12'hB02, 12'hC02: return m_instret;
            12'hF14: return 64'(HART);
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] m_warl(input logic [11:0] a, input logic [63:0] v);
        case (a)
            12'h300: return v & 64'h88;
            12'h304, 12'h344: return v & 64'h888;
            12'h305: return v & ~64'h2;
            12'h341: return v & ~64'h1;
            default: return v;
        endcase
    endfunction

    function automatic bit m_we(input logic [1:0] op, input logic nw);
        return (op == 2'b01) || ((op >= 2'b10) && !nw);
    endfunction

    function automatic bit m_illegal(input logic [11:0] a, input logic [1:0] op, input logic nw);
        return !m_impl(a) || (m_we(op, nw) && (a >= 12'hC00));
    endfunction

    function automatic logic [63:0] m_newval(input logic [1:0] op, input logic [63:0] old, input logic [63:0] w);
        case (op)
            2'b01:   return w;
            2'b10:   return old | w;
            2'b11:   return old & ~w;
            default: return old;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4096; i++) m_mem[i] <= 64'h0;
            m_cycle   <= 64'h0;
            m_instret <= 64'h0;
        end else begin
            if (req_valid_i && m_we(req_op_i, req_nowr_i) && !m_illegal(req_addr_i, req_op_i, req_nowr_i)) begin
                if (req_addr_i inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344})
                    m_mem[req_addr_i] <= m_warl(req_addr_i, m_newval(req_op_i, m_read(req_addr_i), req_wdata_i));
                m_cycle   <= (req_addr_i == 12'hB00) ? m_newval(req_op_i, m_cycle, req_wdata_i) : m_cycle + 64'd1;
                m_instret <= (req_addr_i == 12'hB02) ? m_newval(req_op_i, m_instret, req_wdata_i)
                                                     : m_instret + 64'(retire_i);
            end else begin
                m_cycle   <= m_cycle + 64'd1;
                m_instret <= m_instret + 64'(retire_i);
            end
        end
    end

    // Driver: apply one request right after the falling edge; outputs settle #1 later.
    task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] a,
                         input logic [63:0] w, input logic nw, input logic rt);
        @(negedge clk);
        req_valid_i = v;
        req_op_i    = op;
        req_addr_i  = a;
        req_wdata_i = w;
        req_nowr_i  = nw;
        retire_i    = rt;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 2'b00, 12'h301, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h8000_0000_0000_0100) begin
            n_fail++; $display("FAIL reset_misa: got %h want %h", rdata_o, 64'h8000_0000_0000_0100);
        end
        n_checks++;
        if (illegal_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal_o);
        end
        drive(1'b1, 2'b00, 12'h300, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h1800) begin
            n_fail++; $display("FAIL reset_mstatus: got %h want %h", rdata_o, 64'h1800);
        end
        drive(1'b1, 2'b00, 12'hF14, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'(HART)) begin
            n_fail++; $display("FAIL reset_mhartid: got %h want %h", rdata_o, 64'(HART));
        end
        drive(1'b1, 2'b00, 12'h340, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h0) begin
            n_fail++; $display("FAIL reset_mscratch: got %h want 0", rdata_o);
        end
    endtask

    task automatic test_rw_scratch();
        drive(1'b1, 2'b01, 12'h340, 64'hDEAD_BEEF, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h0) begin
            n_fail++; $display("FAIL rw_old_value: got %h want 0", rdata_o);
        end
        drive(1'b1, 2'b00, 12'h340, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rw_new_value: got %h want %h", rdata_o, 64'hDEAD_BEEF);
        end
    endtask

    task automatic test_set_clear();
        drive(1'b1, 2'b10, 12'h300, 64'h8, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 12'h300, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h1808) begin
            n_fail++; $display("FAIL rs_mstatus: got %h want %h", rdata_o, 64'h1808);
        end
        drive(1'b1, 2'b11, 12'h300, 64'h8, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 12'h300, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h1800) begin
            n_fail++; $display("FAIL rc_mstatus: got %h want %h", rdata_o, 64'h1800);
        end
        drive(1'b1, 2'b10, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drive(1'b1, 2'b00, 12'h300, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h1800) begin
            n_fail++; $display("FAIL rs_nowr_mstatus: got %h want %h", rdata_o, 64'h1800);
        end
    endtask

    task automatic test_illegal();
        logic [63:0] exp;
        drive(1'b1, 2'b01, 12'hC00, 64'hDEAD_0000, 1'b0, 1'b0);
        n_checks++;
        if (illegal_o !== 1'b1) begin
            n_fail++; $display("FAIL rw_readonly_illegal: got %b want 1", illegal_o);
        end
        drive(1'b1, 2'b00, 12'h7FF, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (illegal_o !== 1'b1 || rdata_o !== 64'h0) begin
            n_fail++; $display("FAIL unimpl_addr: got ill=%b data=%h want ill=1 data=0", illegal_o, rdata_o);
        end
        drive(1'b1, 2'b10, 12'hC00, 64'hFF, 1'b1, 1'b0);
        exp = m_read(12'hC00);
        n_checks++;
        if (illegal_o !== 1'b0 || rdata_o !== exp) begin
            n_fail++; $display("FAIL rs_nowr_readonly: got ill=%b data=%h want ill=0 data=%h", illegal_o, rdata_o, exp);
        end
        drive(1'b1, 2'b01, 12'h7FF, 64'h55, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 12'h7FF, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h0) begin
            n_fail++; $display("FAIL unimpl_write_stays_0: got %h want 0", rdata_o);
        end
    endtask

    task automatic test_counters();
        logic [63:0] c0, i0;
        drive(1'b0, 2'b00, 12'hB00, 64'h0, 1'b0, 1'b1);
        c0 = m_cycle;
        i0 = m_instret;
        n_checks++;
        if (rdata_o !== c0) begin
            n_fail++; $display("FAIL mcycle_base: got %h want %h", rdata_o, c0);
        end
        for (int i = 1; i < 10; i++) drive(1'b0, 2'b00, 12'hB00, 64'h0, 1'b0, (i < 4) ? 1'b1 : 1'b0);
        drive(1'b0, 2'b00, 12'hB00, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== c0 + 64'd10) begin
            n_fail++; $display("FAIL mcycle_plus10: got %h want %h", rdata_o, c0 + 64'd10);
        end
        drive(1'b0, 2'b00, 12'hB02, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== i0 + 64'd4) begin
            n_fail++; $display("FAIL minstret_plus4: got %h want %h", rdata_o, i0 + 64'd4);
        end
        drive(1'b1, 2'b01, 12'hB00, 64'd5, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 12'hB00, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'd5) begin
            n_fail++; $display("FAIL mcycle_write: got %h want 5", rdata_o);
        end
        drive(1'b1, 2'b00, 12'hC01, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'd6) begin
            n_fail++; $display("FAIL mcycle_after_write: got %h want 6", rdata_o);
        end
        drive(1'b1, 2'b01, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        drive(1'b1, 2'b00, 12'hC02, 64'h0, 1'b0, 1'b1);
        n_checks++;
        if (rdata_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL minstret_write_wins: got %h want all-ones", rdata_o);
        end
        drive(1'b1, 2'b00, 12'hB02, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h0) begin
            n_fail++; $display("FAIL minstret_wrap: got %h want 0", rdata_o);
        end
    endtask

    task automatic test_warl();
        drive(1'b1, 2'b01, 12'h341, 64'h1003, 1'b0, 1'b0);
        drive(1'b1, 2'b01, 12'h305, 64'h1003, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 12'h341, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h1002) begin
            n_fail++; $display("FAIL mepc_bit0: got %h want %h", rdata_o, 64'h1002);
        end
        drive(1'b1, 2'b00, 12'h305, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h1001) begin
            n_fail++; $display("FAIL mtvec_bit1: got %h want %h", rdata_o, 64'h1001);
        end
        drive(1'b1, 2'b01, 12'h304, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        drive(1'b1, 2'b01, 12'h301, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h8000_0000_0000_0100 || illegal_o !== 1'b0) begin
            n_fail++; $display("FAIL misa_write: got ill=%b data=%h want ill=0 data=%h", illegal_o, rdata_o, 64'h8000_0000_0000_0100);
        end
        drive(1'b1, 2'b00, 12'h304, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h888) begin
            n_fail++; $display("FAIL mie_mask: got %h want %h", rdata_o, 64'h888);
        end
        drive(1'b1, 2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 12'h300, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h1888) begin
            n_fail++; $display("FAIL mstatus_mask: got %h want %h", rdata_o, 64'h1888);
        end
    endtask

    task automatic test_random();
        logic [11:0] addrs [0:19];
        logic [63:0] exp;
        logic        exp_ill;
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                  12'hB00, 12'hB02, 12'hC00, 12'hC01, 12'hC02, 12'hF11, 12'hF14, 12'h7FF, 12'h306,
                  12'hB01, 12'h000};
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), addrs[$urandom_range(0, 19)],
                  {$urandom, $urandom}, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            exp_q.push_back(m_read(req_addr_i));
            exp_ill = m_illegal(req_addr_i, req_op_i, req_nowr_i);
            exp = exp_q.pop_front();
            n_checks++;
            if (rdata_o !== exp) begin
                n_fail++; $display("FAIL rand_rdata addr=%h: got %h want %h", req_addr_i, rdata_o, exp);
            end
            n_checks++;
            if (illegal_o !== exp_ill) begin
                n_fail++; $display("FAIL rand_illegal addr=%h op=%0d: got %b want %b", req_addr_i, req_op_i, illegal_o, exp_ill);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'b01, 12'h340, 64'h1234, 1'b0, 1'b1);
        #2 rstn = 1'b0;
        req_addr_i = 12'hB00;
        #1;
        n_checks++;
        if (rdata_o !== 64'h0) begin
            n_fail++; $display("FAIL async_rst_mcycle: got %h want 0", rdata_o);
        end
        req_addr_i = 12'hB02;
        #1;
        n_checks++;
        if (rdata_o !== 64'h0) begin
            n_fail++; $display("FAIL async_rst_minstret: got %h want 0", rdata_o);
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        retire_i    = 1'b0;
        rstn        = 1'b1;
        drive(1'b1, 2'b00, 12'h340, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata_o !== 64'h0) begin
            n_fail++; $display("FAIL async_rst_write_lost: got %h want 0", rdata_o);
        end
    endtask

    initial begin
        test_reset();
        test_rw_scratch();
        test_set_clear();
        test_illegal();
        test_counters();
        test_warl();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
